// File: rtl/dp_fifo_ctrl.sv
// rtl/dp_fifo_ctrl.sv - FIFO controller over the 16x8 dp_mem with a 3-entry output prefetch buffer
//
// Turns dp_mem into a FIFO with valid/ready handshakes on both sides.
// Optional feature macro: DP_FIFO_LEVEL_EN (adds the registered level output).
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-low reset
//   in_valid/in_ready/in_data     upstream push handshake
//   out_valid/out_ready/out_data  downstream pop handshake, out_data is the FIFO head
//   mem_enb/mem_wr/mem_rd         dp_mem strobes
//   mem_w_addr/mem_r_addr         dp_mem addresses (upper bits always 0)
//   mem_w_data/mem_r_data         dp_mem write data / registered read data
//   level                         words held (memory + in-flight + buffer), DP_FIFO_LEVEL_EN only
module dp_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          mem_enb,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_w_addr,
  output logic [AW-1:0] mem_r_addr,
  output logic [DW-1:0] mem_w_data,
  input  logic [DW-1:0] mem_r_data
`ifdef DP_FIFO_LEVEL_EN
  ,
  output logic [4:0]    level
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   mem_count;
  logic [PW:0]   mem_count_nxt;
  logic [1:0]    obuf_count;
  logic [1:0]    obuf_count_nxt;
  logic [1:0]    wr_idx;
  logic          land;
  logic [DW-1:0] obuf [3];

  logic push;
  logic issue;
  logic pop;

  // A full memory refuses pushes even if a read issues this cycle; this keeps
  // write and read addresses apart whenever both strobes are active.
  assign in_ready = rst & (mem_count != FULL);
  assign push     = in_valid & in_ready;

  // Only issue a read if the buffer has a free slot counting the word already
  // in flight, so a landing word can never overflow the buffer.
  assign issue = rst & (mem_count != '0) & (({1'b0, obuf_count} + {2'b0, land}) < 3'd3);

  assign out_valid = (obuf_count != 2'd0);
  assign out_data  = obuf[0];
  assign pop       = out_valid & out_ready;

  assign mem_wr     = push;
  assign mem_rd     = issue;
  assign mem_enb    = push | issue;
  assign mem_w_addr = rst ? AW'(wptr) : '0;
  assign mem_r_addr = rst ? AW'(rptr) : '0;
  assign mem_w_data = in_data;

  always_comb begin
    mem_count_nxt = mem_count;
    case ({push, issue})
      2'b10:   mem_count_nxt = mem_count + (PW+1)'(1);
      2'b01:   mem_count_nxt = mem_count - (PW+1)'(1);
      default: mem_count_nxt = mem_count;
    endcase
    obuf_count_nxt = obuf_count + {1'b0, land} - {1'b0, pop};
    // Tail slot after the head shift caused by a simultaneous pop.
    wr_idx = obuf_count - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      mem_count  <= '0;
      obuf_count <= '0;
      land       <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + PW'(1);
      if (issue) rptr <= rptr + PW'(1);
      mem_count  <= mem_count_nxt;
      obuf_count <= obuf_count_nxt;
      land       <= issue;
    end
  end

  // Head-at-index-0 shift buffer; the capture write is placed after the shift
  // so it wins when a pop and a capture target the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (pop) begin
        obuf[0] <= obuf[1];
        obuf[1] <= obuf[2];
      end
      if (land) obuf[wr_idx] <= mem_r_data;
    end
  end

`ifdef DP_FIFO_LEVEL_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= '0;
    end else begin
      level <= 5'(mem_count_nxt) + 5'(issue) + 5'(obuf_count_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_dp_fifo_ctrl.sv
// tb/tb_dp_fifo_ctrl.sv - directed scoreboard bench for dp_fifo_ctrl with a behavioural dp_mem
module tb_dp_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          mem_enb;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_w_addr;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_w_data;
  logic [DW-1:0] mem_r_data;
`ifdef DP_FIFO_LEVEL_EN
  logic [4:0]    level;
`endif

  dp_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .mem_enb    (mem_enb),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_w_addr (mem_w_addr),
    .mem_r_addr (mem_r_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
`ifdef DP_FIFO_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural dp_mem: registered read data, write and read on enb.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (!rst) begin
      mem_r_data <= '0;
    end else if (mem_enb) begin
      if (mem_wr) mem[mem_w_addr] <= mem_w_data;
      if (mem_rd) mem_r_data <= mem[mem_r_addr];
    end
  end

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q [$];
  int            n_push = 0;
  int            n_pop  = 0;
  int            tb_wptr = 0;
  int            tb_rptr = 0;
  int            w_wraps = 0;
  int            r_wraps = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  int            step_no = 0;
  int            first_pop_step = -1;
  int            last_pop_step  = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: sample at the falling edge, update the scoreboard, then
  // return 1 time unit after the next rising edge.
  task automatic step();
    logic [DW-1:0] e;
    @(negedge clk);
    if (rst) begin
`ifdef DP_FIFO_LEVEL_EN
      check("level", level, exp_q.size());
`endif
      if (stall_prev) check("stall_stable", out_data, stall_data);
      check("enb", mem_enb, mem_wr | mem_rd);
      check("wr_is_push", mem_wr, in_valid & in_ready);
      if (mem_wr) begin
        check("w_addr", mem_w_addr, tb_wptr);
        if (tb_wptr == DEPTH-1) w_wraps++;
        tb_wptr = (tb_wptr + 1) % DEPTH;
      end
      if (mem_rd) begin
        check("r_addr", mem_r_addr, tb_rptr);
        if (tb_rptr == DEPTH-1) r_wraps++;
        tb_rptr = (tb_rptr + 1) % DEPTH;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        n_push++;
      end
      if (out_valid && out_ready) begin
        check("pop_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
        end
        n_pop++;
        if (first_pop_step < 0) first_pop_step = step_no;
        last_pop_step = step_no;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_prev = 1'b0;
    end
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < budget) begin
      step();
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
    #1;
    check("drain_idle", out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int p0;
    int w0;
    int r0;
    int drops;
    int k;

    // Reset with a word offered: nothing may reach the memory.
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_enb", mem_enb, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_w_addr", mem_w_addr, 0);
    check("rst_r_addr", mem_r_addr, 0);
    check("rst_out_valid", out_valid, 0);
`ifdef DP_FIFO_LEVEL_EN
    check("rst_level", level, 0);
`endif
    rst = 1'b1; in_valid = 1'b0;
    step();

    // Single word latency.
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1;
    check("sw_wr", mem_wr, 1);
    check("sw_w_addr", mem_w_addr, 0);
    check("sw_w_data", mem_w_data, 8'hA5);
    check("sw_rd_e0", mem_rd, 0);
    step();
    in_valid = 1'b0;
    #1;
    check("sw_rd", mem_rd, 1);
    check("sw_r_addr", mem_r_addr, 0);
    check("sw_valid_e1", out_valid, 0);
    step();
    #1;
    check("sw_valid_e1e2", out_valid, 0);
    step();
    #1;
    check("sw_valid_e2", out_valid, 1);
    check("sw_data_e2", out_data, 8'hA5);
    step();
    #1;
    check("sw_empty", out_valid, 0);

    // Fill with out_ready low: exactly DEPTH+3 words accepted.
    out_ready = 1'b0;
    n0 = n_push;
    for (int i = 0; i < 30; i++) begin
      in_valid = ((n_push - n0) <= 8'h14);
      in_data  = 8'(n_push - n0);
      step();
    end
    #1;
    check("fill_count", n_push - n0, 19);
    check("fill_in_ready", in_ready, 0);
    check("fill_head_valid", out_valid, 1);
    check("fill_head", out_data, 8'h00);
`ifdef DP_FIFO_LEVEL_EN
    check("fill_level", level, 19);
`endif
    p0 = n_pop;
    drain(80);
    check("fill_pops", n_pop - p0, 19);

    // Continuous streaming: one per cycle, pointers wrap twice.
    w0 = w_wraps; r0 = r_wraps; p0 = n_pop; drops = 0;
    first_pop_step = -1; step_no = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_valid = (i < 40);
      in_data  = 8'(i);
      #1;
      if (i < 40 && !in_ready) drops++;
      step();
      if (n_pop - p0 == 40) break;
    end
    check("stream_drops", drops, 0);
    check("stream_pops", n_pop - p0, 40);
    check("stream_first", first_pop_step, 3);
    check("stream_last", last_pop_step, 42);
    check("stream_w_wraps", w_wraps - w0, 2);
    check("stream_r_wraps", r_wraps - r0, 2);
    drain(10);

    // Backpressure: out_ready alternates while 20 words stream in.
    n0 = n_push; p0 = n_pop;
    for (int i = 0; i < 100 && (n_pop - p0) < 20; i++) begin
      in_valid  = ((n_push - n0) < 20);
      in_data   = 8'h80 + 8'(n_push - n0);
      out_ready = (i % 2 == 0);
      step();
    end
    check("bp_pushes", n_push - n0, 20);
    check("bp_pops", n_pop - p0, 20);
    drain(10);

    // Reset while 5 words are held and one read is landing.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h50 + 8'(i);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    check("mid_rd_issue", mem_rd, 1);
    step();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    #1;
    check("mid_in_ready", in_ready, 0);
    check("mid_enb", mem_enb, 0);
    check("mid_wr", mem_wr, 0);
    check("mid_rd", mem_rd, 0);
    check("mid_w_addr", mem_w_addr, 0);
    check("mid_r_addr", mem_r_addr, 0);
    step();
    rst = 1'b1; in_valid = 1'b0;
    exp_q.delete(); tb_wptr = 0; tb_rptr = 0; stall_prev = 1'b0;
    #1;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_rd", mem_rd, 0);
`ifdef DP_FIFO_LEVEL_EN
    check("post_rst_level", level, 0);
`endif
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    #1;
    while (!out_valid && k < 10) begin
      step();
      #1;
      k++;
    end
    check("post_rst_first_valid", out_valid, 1);
    check("post_rst_first_data", out_data, 8'h3C);
    drain(10);

    // Simultaneous write and read.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h61 + 8'(i);
      step();
    end
    in_data = 8'h64;
    #1;
    check("sim_wr", mem_wr, 1);
    check("sim_rd", mem_rd, 1);
    check("sim_addr_differ", mem_w_addr != mem_r_addr, 1);
    step();
    p0 = n_pop;
    drain(20);
    check("sim_pops", n_pop - p0, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dp_fifo_ctrl.md
# dp_fifo_ctrl

Synchronous FIFO controller that turns the 16×8 dual-port memory (`dp_mem`) into a first-in/first-out buffer with valid/ready handshakes on both sides. It sits directly upstream of the memory: it generates `enb`, `wr`, `rd`, `w_addr`, `r_addr` and `w_data`, and consumes the memory's registered `r_data`. A 3-entry output prefetch buffer hides the memory's one-cycle read latency, so the FIFO sustains one word per cycle in and out.

## Interface
Parameters:
- `DW`, default 8: data width; must equal the memory data width.
- `AW`, default 5: memory address bus width.
- `DEPTH`, default 16: memory entries; power of 2, ≤ 2^AW.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-low. Shared with `dp_mem`.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  controller accepts a word.
- `in_data`  in  DW  upstream word.
- `out_valid`  out  1  `out_data` holds the FIFO head.
- `out_ready`  in  1  downstream takes the head.
- `out_data`  out  DW  FIFO head word.
- `mem_enb`  out  1  to `dp_mem.enb`.
- `mem_wr`  out  1  to `dp_mem.wr`.
- `mem_rd`  out  1  to `dp_mem.rd`.
- `mem_w_addr`  out  AW  to `dp_mem.w_addr`; the upper bits are always 0.
- `mem_r_addr`  out  AW  to `dp_mem.r_addr`; the upper bits are always 0.
- `mem_w_data`  out  DW  to `dp_mem.w_data`.
- `mem_r_data`  in  DW  from `dp_mem.r_data`.
- `level`  out  5  total words held; present only with `DP_FIFO_LEVEL_EN`.

## Operation
- Push: `push = in_valid & in_ready`.
  - `mem_wr = push`, `mem_w_addr = wptr`, `mem_w_data = in_data`.
  - `wptr` advances at the clock edge and wraps from DEPTH-1 to 0.
- Flow control: `in_ready = rst & (mem_count != DEPTH)`. A push is never accepted on a full memory, even when a pop occurs in the same cycle.
- Read issue: `mem_rd = rst & (mem_count != 0) & (obuf_count + land < 3)`.
  - `mem_r_addr = rptr`.
  - `rptr` advances (and wraps) on issue.
  - `land` is set at the next edge.
- Capture: while `land = 1`, `mem_r_data` is written into the tail of the output buffer at the next edge.
- Output: `out_valid = (obuf_count != 0)`; `out_data` is the buffer head. A pop (`out_valid & out_ready`) removes the head.
- Memory enable: `mem_enb = mem_wr | mem_rd`. Write and read in the same cycle are legal.
  - When both occur, the addresses always differ: a read only targets entries written on earlier edges, and no write happens when the memory is full.
- Counters:
  - `mem_count` (0..DEPTH) is incremented by push and decremented by read issue.
  - `obuf_count` (0..3) is incremented by capture and decremented by pop.
  - Both update in the same cycle without loss when events coincide.
- Ordering: strict FIFO order; no word is ever dropped or duplicated.
- Stability: while `out_valid & !out_ready`, `out_data` is held stable.

## Timing
- Reset values (when `rst` is low at an edge):
  - `wptr`, `rptr`, `mem_count`, `obuf_count`, `land` = 0.
  - `out_valid` = 0 and `level` = 0.
  - While `rst` is low: `in_ready`, `mem_enb`, `mem_wr`, `mem_rd` = 0 and the address outputs = 0.
- Reset mid-operation:
  - All stored and in-flight words are discarded, and a pending `land` is dropped.
  - The memory contents become X and are never read before being rewritten.
- First-word latency:
  - Push accepted at edge E0.
  - `mem_rd` = 1 in the cycle E0–E1.
  - `dp_mem` updates `r_data` at E1.
  - Capture at E2; `out_valid` = 1 from E2.
- Throughput: with `in_valid = out_ready = 1` continuously, one push and one pop per cycle in steady state.
- Capacity: DEPTH + 3 = 19 words.
- `level = mem_count + land + obuf_count`, registered, maximum 19.

## Configuration
- `DP_FIFO_LEVEL_EN` defined: the `level` port and its register are present.
- `DP_FIFO_LEVEL_EN` undefined: the port and its logic are removed; all other behaviour is identical.

## Test plan
- Single word: after reset, push 0xA5 at E0.
  - Expect `mem_wr` = 1 with `w_addr` = 0 during the push cycle.
  - Expect `mem_rd` = 1 with `r_addr` = 0 the next cycle.
  - Expect `out_valid` = 1 with `out_data` = 0xA5 from E2.
- Fill with `out_ready` = 0: offer words 0x00–0x14.
  - Expect exactly 19 accepted (0x00–0x12), then `in_ready` = 0 and `level` = 19.
  - Then set `out_ready` = 1: expect 0x00–0x12 in order, then `out_valid` = 0.
- Stream with `in_valid = out_ready = 1` for 40 words of values i:
  - `in_ready` never drops.
  - Outputs arrive one per cycle after 2 cycles, in order.
  - `w_addr` and `r_addr` wrap 15→0 twice.
- Backpressure: `out_ready` toggles 1,0,1,0 while streaming 20 words.
  - Order is preserved.
  - `out_data` is stable during every stall cycle.
- Reset mid-operation: with 5 words stored and a read landing, pull `rst` low for 1 cycle.
  - Expect `out_valid` = 0, `level` = 0 and `mem_*` = 0.
  - Then push 0x3C: the first output is 0x3C.
- Simultaneous access: while 3 words are stored, push.
  - Expect `mem_wr = mem_rd = 1` in the same cycle with `w_addr` ≠ `r_addr`, and correct data out.
